// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared types and selection helper for priority_encoder_reg
//
// Purpose: FSM state type and the first-set-bit search used by prio_pick.
// Contents:
//   prio_state_e - EMPTY (nothing offered) / HOLD (y offered, valid=1)
//   pick_t       - {found, idx} result of a search
//   pick_first() - first set bit of vec at or above start, wrapping at n-1 -> 0
package prio_enc_pkg;

  localparam int MAXN = 64;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } prio_state_e;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } pick_t;

  // Offsets are scanned from highest to lowest so the smallest offset from
  // start is the last one written and therefore wins.
  function automatic pick_t pick_first(input logic [MAXN-1:0] vec,
                                       input logic [5:0]      start,
                                       input int              n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = MAXN - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(start) + k;
        if (j >= n) j = j - n;
        if (vec[j[5:0]]) begin
          r.found = 1'b1;
          r.idx   = j[5:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational first-set-bit selector with wrap-around start
//
// Purpose: pick the first set bit of cand searching upward from start.
// Ports:
//   cand  [N-1:0] in  - candidate request vector
//   start [W-1:0] in  - search start index (tied to 0 for fixed priority)
//   idx   [W-1:0] out - selected index (meaningful when found)
//   found         out - cand has at least one set bit
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         cand,
  input  logic [$clog2(N)-1:0] start,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int W = $clog2(N);

  logic [MAXN-1:0] vec_ext;
  logic [5:0]      start_ext;
  pick_t           res;

  always_comb begin
    vec_ext          = '0;
    vec_ext[N-1:0]   = cand;
    start_ext        = '0;
    start_ext[W-1:0] = start;
  end

  assign res = pick_first(vec_ext, start_ext, N);
  assign idx = res.idx[W-1:0];
  // A found index is always below N; the range term keeps every result bit live.
  assign found = res.found && (int'(res.idx) < N);

endmodule

// File: rtl/priority_encoder_reg.sv
// rtl/priority_encoder_reg.sv - registered priority encoder with pending requests and handshake
//
// Purpose: collects one-cycle request pulses into a pending register and offers
// one granted index at a time on y/valid, accepted by ready.
// Configuration macro: PRIORITY_ENCODER_RR_EN (rotating priority; default fixed lowest-index).
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   req     [N-1:0] in  - request pulses
//   ready           in  - consumer accepts y when valid && ready
//   err_clr         in  - clears dup_err (a coincident new duplicate wins)
//   y       [W-1:0] out - granted index
//   valid           out - y holds a granted index
//   pend    [N-1:0] out - pending requests not yet granted
//   dup_err         out - sticky: a request arrived for an already pending bit
module priority_encoder_reg
  import prio_enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 ready,
  input  logic                 err_clr,
  output logic [$clog2(N)-1:0] y,
  output logic                 valid,
  output logic [N-1:0]         pend,
  output logic                 dup_err
);

  localparam int W = $clog2(N);

  prio_state_e  state_q;
  logic [W-1:0] y_q;
  logic         valid_q;
  logic [N-1:0] pend_q, pend_d;
  logic         dup_err_q, dup_err_d;

  logic [N-1:0] cand;
  logic [W-1:0] start;
  logic [W-1:0] idx;
  logic         found;
  logic         load;
  logic [N-1:0] sel_oh;
  logic         dup;

`ifdef PRIORITY_ENCODER_RR_EN
  logic [W-1:0] ptr_q;
  assign start = ptr_q;
`else
  assign start = '0;
`endif

  assign cand = pend_q | req;

  prio_pick #(.N(N)) u_pick (
    .cand  (cand),
    .start (start),
    .idx   (idx),
    .found (found)
  );

  assign load   = ((state_q == EMPTY) || ready) && found;
  assign sel_oh = load ? (N'(1) << idx) : '0;
  assign pend_d = cand & ~sel_oh;
  // The bit granted on this edge is not a duplicate; a request for the index
  // already in y is not in pend (it left on its load edge), so it is new.
  assign dup       = |(req & pend_q & ~sel_oh);
  assign dup_err_d = dup | (dup_err_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      y_q       <= '0;
      valid_q   <= 1'b0;
      pend_q    <= '0;
      dup_err_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      dup_err_q <= dup_err_d;
      case (state_q)
        EMPTY: begin
          if (found) begin
            y_q     <= idx;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            if (found) begin
              y_q <= idx;
            end else begin
              valid_q <= 1'b0;
              state_q <= EMPTY;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= EMPTY;
        end
      endcase
    end
  end

`ifdef PRIORITY_ENCODER_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (load) begin
      ptr_q <= (idx == W'(N - 1)) ? '0 : idx + W'(1);
    end
  end
`endif

  assign y       = y_q;
  assign valid   = valid_q;
  assign pend    = pend_q;
  assign dup_err = dup_err_q;

endmodule

// File: tb/tb_priority_encoder_reg.sv
// tb/tb_priority_encoder_reg.sv - self-checking bench for priority_encoder_reg
module tb_priority_encoder_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] y;
  logic       valid;
  logic [7:0] pend;
  logic       dup_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  priority_encoder_reg #(.N(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ready   (ready),
    .err_clr (err_clr),
    .y       (y),
    .valid   (valid),
    .pend    (pend),
    .dup_err (dup_err)
  );

  // Reference model: outputs as the rules describe them, with integer search.
  bit       m_valid;
  int       m_y;
  bit [7:0] m_pend;
  bit       m_dup;
  int       m_ptr;
  bit [7:0] m_cand;
  bit [7:0] m_clr;
  int       m_sel;
  bit       m_ld;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_y = 0; m_pend = '0; m_dup = 0; m_ptr = 0;
    end else begin
      m_cand = m_pend | req;
      m_sel  = -1;
      for (int k = 0; k < 8; k++) begin
        if (m_sel < 0 && m_cand[(m_ptr + k) % 8]) m_sel = (m_ptr + k) % 8;
      end
      m_ld  = (!m_valid || ready) && (m_sel >= 0);
      m_clr = m_ld ? 8'(1 << m_sel) : 8'h00;
      if ((req & m_pend & ~m_clr) != 0) m_dup = 1;
      else if (err_clr) m_dup = 0;
      m_pend = m_cand & ~m_clr;
      if (m_ld) begin
        m_y = m_sel;
        m_valid = 1;
`ifdef PRIORITY_ENCODER_RR_EN
        m_ptr = (m_sel + 1) % 8;
`endif
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 64'(valid), 64'(m_valid));
      check("pend", 64'(pend), 64'(m_pend));
      check("dup_err", 64'(dup_err), 64'(m_dup));
      if (m_valid) check("y", 64'(y), 64'(m_y));
    end
  end

  // Inputs applied at a negedge, consumed at the next posedge; returns at the following negedge.
  task automatic step(input logic [7:0] r, input logic rd, input logic ec);
    req = r; ready = rd; err_clr = ec;
    @(negedge clk);
  endtask

  task automatic expect_out(input string nm, input bit v, input int yy, input logic [7:0] p, input bit d);
    check({nm, "_valid"}, 64'(valid), 64'(v));
    if (v) check({nm, "_y"}, 64'(y), 64'(yy));
    check({nm, "_pend"}, 64'(pend), 64'(p));
    check({nm, "_dup"}, 64'(dup_err), 64'(d));
  endtask

  initial begin
    @(negedge clk);
    // Reset with all requests high
    rst_n = 0;
    step(8'hFF, 1, 0);
    chk_en = 1;
    expect_out("reset", 0, 0, 8'h00, 0);
    check("reset_y", 64'(y), 64'd0);
    rst_n = 1;

    // Single request
    step(8'b0000_0100, 1, 0);
    expect_out("single", 1, 2, 8'h00, 0);
    check("model_single_y", 64'(m_y), 64'd2);
    step(8'h00, 1, 0);
    expect_out("single_drain", 0, 0, 8'h00, 0);

    // Burst: lowest index first
    step(8'b1001_0010, 1, 0);
    expect_out("burst0", 1, 1, 8'h90, 0);
    check("model_burst_pend", 64'(m_pend), 64'h90);
    step(8'h00, 1, 0);
    expect_out("burst1", 1, 4, 8'h80, 0);
    step(8'h00, 1, 0);
    expect_out("burst2", 1, 7, 8'h00, 0);
    step(8'h00, 1, 0);
    expect_out("burst_end", 0, 0, 8'h00, 0);

    // Backpressure
    step(8'h08, 0, 0);
    expect_out("bp_load", 1, 3, 8'h00, 0);
    step(8'h01, 0, 0);
    expect_out("bp_hold", 1, 3, 8'h01, 0);
    step(8'h00, 0, 0);
    expect_out("bp_hold2", 1, 3, 8'h01, 0);
    step(8'h00, 1, 0);
    expect_out("bp_release", 1, 0, 8'h00, 0);
    step(8'h00, 1, 0);
    expect_out("bp_end", 0, 0, 8'h00, 0);

    // Duplicate on a pending bit
    step(8'h01, 0, 0);
    step(8'h20, 0, 0);
    expect_out("dup_pend", 1, 0, 8'h20, 0);
    step(8'h20, 0, 0);
    expect_out("dup_set", 1, 0, 8'h20, 1);
    check("model_dup", 64'(m_dup), 64'd1);
    step(8'h00, 1, 0);
    expect_out("dup_grant", 1, 5, 8'h00, 1);
    step(8'h00, 1, 0);
    expect_out("dup_single", 0, 0, 8'h00, 1);
    step(8'h00, 1, 1);
    expect_out("dup_clr", 0, 0, 8'h00, 0);

    // Set wins over clear
    step(8'h01, 0, 0);
    step(8'h20, 0, 0);
    step(8'h20, 0, 1);
    expect_out("set_wins", 1, 0, 8'h20, 1);
    step(8'h00, 1, 1);
    expect_out("set_wins_clr", 1, 5, 8'h00, 0);
    step(8'h00, 1, 0);

    // Request for the index held in y is new, not a duplicate
    step(8'h01, 0, 0);
    step(8'h01, 0, 0);
    expect_out("same_idx", 1, 0, 8'h01, 0);
    step(8'h00, 1, 0);
    expect_out("same_idx_regrant", 1, 0, 8'h00, 0);
    step(8'h00, 1, 0);

    // Fresh pointer for the two-bit pattern
    rst_n = 0;
    step(8'h00, 0, 0);
    rst_n = 1;
    step(8'h03, 1, 0);
    expect_out("pair_a0", 1, 0, 8'h02, 0);
    step(8'h00, 1, 0);
    expect_out("pair_a1", 1, 1, 8'h00, 0);
    step(8'h00, 1, 0);
    step(8'h03, 1, 0);
    expect_out("pair_b0", 1, 0, 8'h02, 0);
    step(8'h00, 1, 0);
    expect_out("pair_b1", 1, 1, 8'h00, 0);
    step(8'h00, 1, 0);
    step(8'h01, 1, 0);
    step(8'h00, 1, 0);
    step(8'h03, 1, 0);
`ifdef PRIORITY_ENCODER_RR_EN
    expect_out("rr_ptr1", 1, 1, 8'h01, 0);
    step(8'h00, 1, 0);
    expect_out("rr_ptr1_next", 1, 0, 8'h00, 0);
`else
    expect_out("fixed_low", 1, 0, 8'h02, 0);
    step(8'h00, 1, 0);
    expect_out("fixed_low_next", 1, 1, 8'h00, 0);
`endif
    step(8'h00, 1, 0);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      step(($urandom_range(0, 2) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/priority_encoder_reg.md
PRIORITY_ENCODER_REG -- requirements
Module: priority_encoder_reg

Interface
REQ-001 SHALL have parameter N, default 8, number of request inputs; legal range 2..64.
REQ-002 SHALL have localparam W = $clog2(N), the output index width; it is not overridable.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; synchronous and active-low.
REQ-005 SHALL have port req, input, N bits, request pulses; bit i high for one cycle raises request i.
REQ-006 SHALL have port y, output, W bits, registered index of the granted request.
REQ-007 SHALL have port valid, output, 1 bit; y holds a granted index.
REQ-008 SHALL have port ready, input, 1 bit; the consumer accepts y on a cycle where valid && ready.
REQ-009 SHALL have port pend, output, N bits, the pending-request register.
REQ-010 SHALL have port dup_err, output, 1 bit, sticky duplicate-request flag.
REQ-011 SHALL have port err_clr, input, 1 bit, clears dup_err.

Function
REQ-012 SHALL form candidate vector cand = pend | req each cycle.
REQ-013 SHALL follow a two-state FSM: EMPTY (valid=0) and HOLD (valid=1).
REQ-014 SHALL define load as (state==EMPTY || ready) && cand != 0.
- On load: y <= selected index; state <= HOLD.
- EMPTY with cand == 0: stay in EMPTY.
- HOLD && ready && cand == 0: go to EMPTY.
- HOLD && !ready: hold y and state unchanged.
REQ-015 SHALL, in fixed mode, select the lowest set index of cand.
REQ-016 SHALL update pend <= cand & ~(load ? onehot(selected) : 0).
- The granted bit leaves pend on the same edge that loads y.
REQ-017 SHALL give one-cycle latency: a req bit at edge k into idle logic gives valid=1 and y=i after edge k.
REQ-018 SHALL support back-to-back grants: with cand nonzero and ready held high, valid stays high and a new index is loaded every cycle.
REQ-019 SHALL set dup_err on any edge where (req & pend & ~cleared_bit) != 0; the duplicate merges and only one grant results.
REQ-020 SHALL treat a req bit equal to the index currently held in y as a new pending request, not a duplicate.
REQ-021 SHALL, when err_clr and a new duplicate coincide, let set win.

Reset
REQ-022 SHALL, when rst_n=0 at an edge, force state=EMPTY, valid=0, y=0, pend=0, dup_err=0, and the rotation pointer to 0.
REQ-023 SHALL ignore req during reset; a grant in flight is discarded without handshake.

Configuration
REQ-024 SHALL select rotating priority with macro PRIORITY_ENCODER_RR_EN.
- Defined: a W-bit pointer ptr is kept.
- Selection is the first set bit of cand searching upward from ptr, wrapping N-1 -> 0.
- On each load, ptr <= (selected+1) mod N.
- Undefined: fixed lowest-index priority per REQ-015; no pointer register exists.

Structure
REQ-025 SHALL place in shared package prio_enc_pkg:
- the FSM state typedef (EMPTY, HOLD);
- function pick_first(vector, start) returning the index plus a found flag.
REQ-026 SHALL implement selection in one combinational sub-module prio_pick (parameter N; inputs cand and start; outputs idx and found).
- Fixed mode ties start to 0.

Verification
REQ-027 SHALL cover these directed scenarios (N=8):
- Reset: rst_n=0 with req=8'hFF -> valid=0, pend=0, y=0 after the edge.
- Single: req=8'b0000_0100 one cycle, ready=1 -> next cycle valid=1, y=2; then valid=0.
- Burst, fixed mode: req=8'b1001_0010 one cycle, ready=1 -> y=1,4,7 on consecutive cycles; pend drains to 0.
- Backpressure: ready=0 while y=3 held -> y and valid stable; req=8'h01 is added to pend; ready=1 -> y=0 next.
- Duplicate: pend bit 5 set, req bit 5 again -> dup_err=1, exactly one grant of 5; err_clr -> dup_err=0.
- RR_EN: req=8'b0000_0011 twice (second pulse after the first two grants) -> grants 0,1, then 0,1 again; with ptr=1 and cand=8'b0000_0011 -> grant 1 first.
